// File: rtl/dvi_pkg.sv
// Shared DVI package: fetch state encodings and sync polarity helpers.
// Also used by the timing generator.
package dvi_pkg;

   localparam int W_STATE = 2;

   typedef enum logic [W_STATE-1:0] {
      S_IDLE    = 2'd0,
      S_WAIT_VS = 2'd1,
      S_FETCH   = 2'd2,
      S_DRAIN   = 2'd3
   } dvi_state_e;

   function automatic logic sync_active(
      input logic lvl,
      input logic pol
   );
      return lvl == pol;
   endfunction

endpackage

// File: rtl/dvi_fetch_credit.sv
// Outstanding-word counter and FIFO credit check for the fetch scheduler.
// credit_ok already accounts for a burst accepted in the current cycle.
module dvi_fetch_credit
   import dvi_pkg::*;
#(
   parameter int BURST      = 8,
   parameter int FIFO_DEPTH = 64,
   parameter int W_LVL      = 7,
   parameter int W_OUT      = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             accept,
   input  logic             rdata_valid,
   input  logic [W_LVL-1:0] fifo_level,
   output logic [W_OUT-1:0] outstanding,
   output logic             credit_ok
);

   localparam int W_SUM = W_OUT + W_LVL + 1;

   logic [W_OUT-1:0] out_q;
   logic [W_OUT-1:0] out_d;
   logic [W_OUT-1:0] out_add;
   logic [W_SUM-1:0] committed;

   always_comb begin
      out_add = accept ? W_OUT'(BURST) : '0;
      out_d   = out_q + out_add;
      if (rdata_valid && (out_d != '0)) begin
         out_d = out_d - W_OUT'(1);
      end
      if (clear) begin
         out_d = '0;
      end
      // Data returning this cycle is not yet visible in fifo_level, so ignore it.
      committed = W_SUM'(fifo_level) + W_SUM'(out_q)
                + W_SUM'(out_add) + W_SUM'(BURST);
      credit_ok = committed <= W_SUM'(FIFO_DEPTH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign outstanding = out_q;

endmodule

// File: rtl/dvi_fetch_ctrl.sv
// Per-frame framebuffer burst fetch scheduler for the DVI pixel FIFO.
// Define DVI_FETCH_LINE_DOUBLE_EN to fetch every source line twice.
module dvi_fetch_ctrl
   import dvi_pkg::*;
#(
   parameter int   W_ADDR          = 32,
   parameter int   W_DATA          = 32,
   parameter int   LINE_WORDS      = 160,
   parameter int   V_LINES         = 480,
   parameter int   BURST           = 8,
   parameter int   FIFO_DEPTH      = 64,
   parameter logic V_SYNC_POLARITY = 1'b0,
   localparam int  W_LVL           = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [W_ADDR-1:0] fb_base,
   input  logic              vsync,
   input  logic              den,
   input  logic [W_LVL-1:0]  fifo_level,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [W_ADDR-1:0] req_addr,
   input  logic              rdata_valid,
   output logic              underflow,
   output logic              busy
);

   localparam int W_OUT   = $clog2(FIFO_DEPTH + 1);
   localparam int W_WORDS = $clog2(LINE_WORDS + 1);
   localparam int W_LINES = $clog2(V_LINES + 1);

   localparam int BURST_BYTES = BURST * W_DATA / 8;
   localparam int LINE_BYTES  = LINE_WORDS * W_DATA / 8;

   localparam logic [W_ADDR-1:0]  BB         = W_ADDR'(BURST_BYTES);
   localparam logic [W_ADDR-1:0]  LB         = W_ADDR'(LINE_BYTES);
   localparam logic [W_ADDR-1:0]  ALIGN_MASK = ~(W_ADDR'(BURST_BYTES - 1));
   localparam logic [W_WORDS-1:0] WORDS_FULL = W_WORDS'(LINE_WORDS);
   localparam logic [W_WORDS-1:0] WORDS_BRST = W_WORDS'(BURST);
   localparam logic [W_LINES-1:0] LINES_FULL = W_LINES'(V_LINES);
   localparam logic [W_LINES-1:0] LINES_ONE  = W_LINES'(1);

   dvi_state_e         state_q, state_d;
   logic               vs_prev_q, vs_prev_d;
   logic               req_valid_q, req_valid_d;
   logic [W_ADDR-1:0]  req_addr_q, req_addr_d;
   logic [W_ADDR-1:0]  line_addr_q, line_addr_d;
   logic [W_WORDS-1:0] words_q, words_d;
   logic [W_LINES-1:0] lines_q, lines_d;
   logic               busy_q, busy_d;
   logic               underflow_q, underflow_d;
`ifdef DVI_FETCH_LINE_DOUBLE_EN
   logic               rep_q, rep_d;
`endif

   logic             vs_act;
   logic             vs_edge;
   logic             accept;
   logic             credit_clear;
   logic             credit_ok;
   logic [W_OUT-1:0] outstanding;

   assign accept = req_valid_q & req_ready & en;

   dvi_fetch_credit #(
      .BURST      (BURST),
      .FIFO_DEPTH (FIFO_DEPTH),
      .W_LVL      (W_LVL),
      .W_OUT      (W_OUT)
   ) u_credit (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (credit_clear),
      .accept      (accept),
      .rdata_valid (rdata_valid),
      .fifo_level  (fifo_level),
      .outstanding (outstanding),
      .credit_ok   (credit_ok)
   );

   always_comb begin
      vs_act       = sync_active(vsync, V_SYNC_POLARITY);
      vs_edge      = vs_act & ~vs_prev_q;
      state_d      = state_q;
      vs_prev_d    = vs_act;
      req_valid_d  = req_valid_q;
      req_addr_d   = req_addr_q;
      line_addr_d  = line_addr_q;
      words_d      = words_q;
      lines_d      = lines_q;
      busy_d       = busy_q;
      underflow_d  = underflow_q | (den & (fifo_level == '0));
      credit_clear = 1'b0;
`ifdef DVI_FETCH_LINE_DOUBLE_EN
      rep_d        = rep_q;
`endif
      if (!en) begin
         state_d      = S_IDLE;
         req_valid_d  = 1'b0;
         busy_d       = 1'b0;
         underflow_d  = 1'b0;
         credit_clear = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_WAIT_VS;
            end
            S_WAIT_VS: begin
               if (vs_edge) begin
                  line_addr_d = fb_base & ALIGN_MASK;
                  req_addr_d  = fb_base & ALIGN_MASK;
                  words_d     = WORDS_FULL;
                  lines_d     = LINES_FULL;
                  busy_d      = 1'b1;
                  req_valid_d = credit_ok;
                  state_d     = S_FETCH;
`ifdef DVI_FETCH_LINE_DOUBLE_EN
                  rep_d       = 1'b0;
`endif
               end
            end
            S_FETCH: begin
               if (accept) begin
                  req_addr_d = req_addr_q + BB;
                  words_d    = words_q - WORDS_BRST;
                  if (words_q == WORDS_BRST) begin
                     words_d = WORDS_FULL;
                     lines_d = lines_q - LINES_ONE;
`ifdef DVI_FETCH_LINE_DOUBLE_EN
                     // First pass of a source line replays it; second pass advances.
                     if (!rep_q) begin
                        rep_d      = 1'b1;
                        req_addr_d = line_addr_q;
                     end else begin
                        rep_d       = 1'b0;
                        line_addr_d = line_addr_q + LB;
                        req_addr_d  = line_addr_q + LB;
                     end
`else
                     line_addr_d = line_addr_q + LB;
                     req_addr_d  = line_addr_q + LB;
`endif
                     if (lines_q == LINES_ONE) begin
                        state_d = S_DRAIN;
                     end
                  end
               end
               req_valid_d = (state_d == S_FETCH) &&
                             ((req_valid_q && !accept) || credit_ok);
            end
            S_DRAIN: begin
               req_valid_d = 1'b0;
               if (outstanding == '0) begin
                  busy_d  = 1'b0;
                  state_d = S_WAIT_VS;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         vs_prev_q   <= 1'b1;
         req_valid_q <= 1'b0;
         req_addr_q  <= '0;
         line_addr_q <= '0;
         words_q     <= '0;
         lines_q     <= '0;
         busy_q      <= 1'b0;
         underflow_q <= 1'b0;
`ifdef DVI_FETCH_LINE_DOUBLE_EN
         rep_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         vs_prev_q   <= vs_prev_d;
         req_valid_q <= req_valid_d;
         req_addr_q  <= req_addr_d;
         line_addr_q <= line_addr_d;
         words_q     <= words_d;
         lines_q     <= lines_d;
         busy_q      <= busy_d;
         underflow_q <= underflow_d;
`ifdef DVI_FETCH_LINE_DOUBLE_EN
         rep_q       <= rep_d;
`endif
      end
   end

   assign req_valid = req_valid_q;
   assign req_addr  = req_addr_q;
   assign busy      = busy_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_dvi_fetch_ctrl.sv
// Scoreboard bench for dvi_fetch_ctrl with a FIFO/memory model.
// Honours DVI_FETCH_LINE_DOUBLE_EN in its address model.
`timescale 1ns/1ps
module tb_dvi_fetch_ctrl;

   localparam int W_ADDR     = 32;
   localparam int W_DATA     = 32;
   localparam int LINE_WORDS = 160;
   localparam int V_LINES    = 4;
   localparam int BURST      = 8;
   localparam int FIFO_DEPTH = 64;
   localparam int W_LVL      = $clog2(FIFO_DEPTH) + 1;
   localparam int BPL        = LINE_WORDS / BURST;
   localparam int WB         = W_DATA / 8;
   localparam int NREQ       = V_LINES * BPL;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en = 1'b0;
   logic              vsync = 1'b1;
   logic              den = 1'b0;
   logic              req_ready = 1'b0;
   logic              rdata_valid = 1'b0;
   logic [W_ADDR-1:0] fb_base = '0;
   logic [W_LVL-1:0]  fifo_level = '0;
   logic              req_valid;
   logic              underflow;
   logic              busy;
   logic [W_ADDR-1:0] req_addr;

   int n_tests = 0;
   int n_fail  = 0;

   logic [W_ADDR-1:0] exp_q[$];
   int                nreq = 0;
   logic [W_ADDR-1:0] last_addr = '0;
   logic              hs_n = 1'b0;

   int   lvl = 0;
   int   pending = 0;
   int   rcnt = 0;
   int   max_lvl = 0;
   int   rd_mode = 0;
   int   den_mode = 0;
   logic env_reset = 1'b1;

   always #5 clk = ~clk;

   dvi_fetch_ctrl #(
      .W_ADDR          (W_ADDR),
      .W_DATA          (W_DATA),
      .LINE_WORDS      (LINE_WORDS),
      .V_LINES         (V_LINES),
      .BURST           (BURST),
      .FIFO_DEPTH      (FIFO_DEPTH),
      .V_SYNC_POLARITY (1'b0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .fb_base     (fb_base),
      .vsync       (vsync),
      .den         (den),
      .fifo_level  (fifo_level),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .rdata_valid (rdata_valid),
      .underflow   (underflow),
      .busy        (busy)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: burst k of a frame, by output line and position in line.
   function automatic logic [W_ADDR-1:0] exp_addr(
      input logic [W_ADDR-1:0] base, input int k);
      int line;
      int src;
      int w;
      line = k / BPL;
      w    = k % BPL;
`ifdef DVI_FETCH_LINE_DOUBLE_EN
      src  = line / 2;
`else
      src  = line;
`endif
      return base + W_ADDR'(src * LINE_WORDS * WB + w * BURST * WB);
   endfunction

   task automatic push_frame(input logic [W_ADDR-1:0] base);
      for (int k = 0; k < NREQ; k++) exp_q.push_back(exp_addr(base, k));
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Monitor: every completed handshake is checked against the scoreboard.
   initial forever begin
      @(negedge clk);
      hs_n = req_valid && req_ready && en && rst_n;
      if (hs_n) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_req: got 0x%0h expected none", req_addr);
         end else begin
            chk("req_addr", req_addr, exp_q.pop_front());
         end
         nreq++;
         last_addr = req_addr;
      end
   end

   // Memory and pixel FIFO model.
   initial forever begin
      int nl;
      @(posedge clk);
      #1;
      if (env_reset) begin
         lvl = 0;
         pending = 0;
         rdata_valid = 1'b0;
         den = 1'b0;
      end else begin
         nl = lvl;
         if (den && lvl > 0) nl--;
         if (rdata_valid) begin
            nl++;
            pending--;
            rcnt++;
         end
         lvl = nl;
         if (hs_n) pending += BURST;
         rdata_valid = (pending > 0) &&
            (rd_mode == 1 || (rd_mode == 2 && $urandom_range(3) != 0));
         den = (den_mode == 2) ||
            (den_mode == 1 && lvl > 0 && $urandom_range(1) == 1);
      end
      if (lvl > max_lvl) max_lvl = lvl;
      fifo_level = W_LVL'(lvl);
   end

   task automatic start_frame(input logic [W_ADDR-1:0] base,
                              output logic v1, output logic b1);
      fb_base = base;
      nreq    = 0;
      rcnt    = 0;
      max_lvl = 0;
      push_frame(base);
      vsync = 1'b0;
      tick(1);
      v1 = req_valid;
      b1 = busy;
      tick(1);
      vsync = 1'b1;
   endtask

   task automatic run_frame_end(input logic [W_ADDR-1:0] base,
                                input string tag);
      bit done = 1'b0;
      for (int i = 0; i < 30000; i++) begin
         if (i == 300) vsync = 1'b0;
         if (i == 303) vsync = 1'b1;
         tick(1);
         if (!busy) begin
            done = 1'b1;
            break;
         end
      end
      chk({tag, "_busy_fall"}, 64'(done), 64'd1);
      chk({tag, "_nreq"}, 64'(nreq), 64'(NREQ));
      chk({tag, "_last_addr"}, 64'(last_addr), 64'(exp_addr(base, NREQ - 1)));
      chk({tag, "_rdata_cnt"}, 64'(rcnt), 64'(V_LINES * LINE_WORDS));
      chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
      chk({tag, "_fifo_bound"}, 64'(max_lvl <= FIFO_DEPTH), 64'd1);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W_ADDR-1:0] base;
      logic              v1;
      logic              b1;
      logic [W_ADDR-1:0] a;
      bit                seen;

      tick(2);
      chk("rst_req_valid", 64'(req_valid), 64'd0);
      chk("rst_req_addr", 64'(req_addr), 64'd0);
      chk("rst_underflow", 64'(underflow), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);

      // Zero-latency memory, no display: fill FIFO exactly once.
      rst_n = 1'b1;
      en = 1'b1;
      env_reset = 1'b0;
      rd_mode = 1;
      den_mode = 0;
      req_ready = 1'b1;
      tick(3);
      chk("idle_no_req", 64'(req_valid), 64'd0);
      base = $urandom & 32'hFFFF_F000;
      start_frame(base, v1, b1);
      chk("first_req_latency", 64'(v1), 64'd1);
      chk("busy_at_start", 64'(b1), 64'd1);
      tick(200);
      chk("fill_nreq", 64'(nreq), 64'(FIFO_DEPTH / BURST));
      chk("fill_stall", 64'(req_valid), 64'd0);
      chk("fill_level", 64'(lvl), 64'(FIFO_DEPTH));
      chk("fill_busy", 64'(busy), 64'd1);

      // Display drains; rest of the frame with random memory latency.
      den_mode = 1;
      rd_mode = 2;
      run_frame_end(base, "frame1");

      // Back-pressure on the request port.
      req_ready = 1'b0;
      base = $urandom & 32'hFFFF_F000;
      start_frame(base, v1, b1);
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (req_valid) begin
            seen = 1'b1;
            break;
         end
         tick(1);
      end
      chk("stall_valid_seen", 64'(seen), 64'd1);
      a = req_addr;
      chk("stall_first_addr", 64'(a), 64'(base));
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("stall_valid_hold", 64'(req_valid), 64'd1);
         chk("stall_addr_hold", 64'(req_addr), 64'(a));
      end
      req_ready = 1'b1;
      tick(1);
      req_ready = 1'b0;
      tick(3);
      chk("stall_one_accept", 64'(nreq), 64'd1);
      req_ready = 1'b1;
      run_frame_end(base, "frame2");

      // Underflow flag.
      en = 1'b0;
      env_reset = 1'b1;
      den_mode = 0;
      tick(2);
      en = 1'b1;
      env_reset = 1'b0;
      tick(3);
      chk("uf_idle", 64'(underflow), 64'd0);
      den_mode = 2;
      tick(1);
      den_mode = 0;
      chk("uf_not_early", 64'(underflow), 64'd0);
      tick(1);
      chk("uf_set", 64'(underflow), 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("uf_sticky", 64'(underflow), 64'd1);
      end
      en = 1'b0;
      tick(1);
      chk("uf_clear_en", 64'(underflow), 64'd0);

      // Abort mid-fetch, then restart on the next vsync.
      en = 1'b1;
      den_mode = 1;
      rd_mode = 2;
      tick(3);
      base = $urandom & 32'hFFFF_F000;
      start_frame(base, v1, b1);
      seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (nreq >= 10) begin
            seen = 1'b1;
            break;
         end
         tick(1);
      end
      chk("abort_progress", 64'(seen), 64'd1);
      en = 1'b0;
      exp_q.delete();
      env_reset = 1'b1;
      tick(1);
      chk("abort_req_valid", 64'(req_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      en = 1'b1;
      env_reset = 1'b0;
      tick(20);
      chk("reen_wait_valid", 64'(req_valid), 64'd0);
      chk("reen_wait_busy", 64'(busy), 64'd0);
      start_frame(base, v1, b1);
      chk("reen_first_req", 64'(v1), 64'd1);
      run_frame_end(base, "frame3");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
